vga_timing_gen: RTL

//   Parametrised raster timing generator; next generation of the fixed 640x480 sync generator.

---
 rtl/vga_timing_gen.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Purpose : parametrised raster timing generator with internal pixel-clock enable,
//           registered zero-skew outputs, line/frame strobes and frame counter.
// Latency : outputs update on the clk edge where pix_ce is high; strobes last 1 clk.
// Backpressure: none; free-running source, consumers qualify with pix_ce.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   pix_ce                     pixel enable, high one clk in every CE_DIV
//   hsync, vsync               sync outputs, active level per HSYNC_POL/VSYNC_POL
//   display_on                 visible-region flag for the current pixel
//   hpos, vpos                 current pixel column / line
//   line_start, frame_start    one-clk pulses when hpos / (hpos,vpos) become 0 / (0,0)
//   frame_count                number of frame_start pulses since reset (wrapping)
//   rgb                        4:4:4 colour-bar test pattern, only when VGA_TESTPAT_EN
//                              is defined; without it the port and pattern logic are absent.
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CE_DIV    = 4,
    parameter int   CNT_W     = 12,
    parameter int   FC_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pix_ce,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic [CNT_W-1:0] hpos,
    output logic [CNT_W-1:0] vpos,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_count
`ifdef VGA_TESTPAT_EN
    ,
    output logic [11:0]      rgb
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_ce_q, pix_ce_d;
    // Internal position starts at the last pixel so the first advance lands on (0,0).
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic [CNT_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             disp_q, disp_d, disp_nxt;
    logic             line_q, line_d, frame_q, frame_d;
    logic [FC_W-1:0]  fc_q, fc_d;
`ifdef VGA_TESTPAT_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
    logic [11:0] rgb_q, rgb_d;
    logic [2:0]  bar;
`endif

    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        // Registered so pix_ce is high during the clk in which div_q == CE_DIV-1.
        pix_ce_d = (div_d == DIV_LAST);

        h_nxt = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        if (h_q == H_LAST) begin
            v_nxt = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            v_nxt = v_q;
        end
        disp_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);

        h_d     = h_q;
        v_d     = v_q;
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        disp_d  = disp_q;
        line_d  = 1'b0;
        frame_d = 1'b0;
        fc_d    = fc_q;

        // Every pixel-describing output is derived from the same next position,
        // so they all change together on the advancing edge.
        if (pix_ce_q) begin
            h_d     = h_nxt;
            v_d     = v_nxt;
            hpos_d  = h_nxt;
            vpos_d  = v_nxt;
            hsync_d = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
            disp_d  = disp_nxt;
            line_d  = (h_nxt == '0);
            frame_d = (h_nxt == '0) && (v_nxt == '0);
            if (frame_d) begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

`ifdef VGA_TESTPAT_EN
    always_comb begin
        bar   = 3'(h_nxt / BAR_W);
        rgb_d = rgb_q;
        if (pix_ce_q) begin
            if (!disp_nxt) begin
                rgb_d = 12'h000;
            end else begin
                case (bar)
                    3'd0:    rgb_d = 12'hFFF;
                    3'd1:    rgb_d = 12'hFF0;
                    3'd2:    rgb_d = 12'h0FF;
                    3'd3:    rgb_d = 12'h0F0;
                    3'd4:    rgb_d = 12'hF0F;
                    3'd5:    rgb_d = 12'hF00;
                    3'd6:    rgb_d = 12'h00F;
                    default: rgb_d = 12'h000;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            pix_ce_q <= 1'b0;
            h_q      <= H_LAST;
            v_q      <= V_LAST;
            hpos_q   <= '0;
            vpos_q   <= '0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            disp_q   <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            fc_q     <= '0;
        end else begin
            div_q    <= div_d;
            pix_ce_q <= pix_ce_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            disp_q   <= disp_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
            fc_q     <= fc_d;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = disp_q;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign frame_count = fc_q;

endmodule
